// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions for the compression core and the W-schedule
//   generator: round constants K[0..63], initial hash value IV, the
//   compression FSM state type, and the FIPS 180-4 bit functions
//   (Sigma0/Sigma1/Ch/Maj for rounds, sigma0/sigma1 for the schedule).
//   No ports (package).
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Element 0 is the most significant word, so H0 lands in bits [255:224].
    typedef logic [0:7][31:0] hash_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round
//   Combinational single SHA-256 compression round.
//   Ports:
//     state_in   in  256  working variables {a,b,c,d,e,f,g,h}, a in MSBs
//     k          in  32   round constant K[t]
//     w          in  32   schedule word W[t]
//     state_out  out 256  working variables after the round
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t       state_in,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output hash_t       state_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = state_in[7] + big_sigma1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
        t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
        state_out = {t1 + t2, state_in[0], state_in[1], state_in[2],
                     state_in[3] + t1, state_in[4], state_in[5], state_in[6]};
    end

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress
//   Reads W[0..63] from the message-schedule generator once it signals
//   ready, runs 64 compression rounds (one per cycle), folds the working
//   variables into the hash state and presents the digest with a pulse.
//   Optional build macro: SHA256_CHAIN_EN (hash state persists across
//   blocks; new_msg=1 restarts from IV).
//   Ports:
//     clock     in   1    system clock, rising edge
//     reset     in   1    asynchronous, active-low reset
//     w_rdy     in   1    schedule-ready level; a 0->1 edge in IDLE starts a block
//     w_data    in   32   W word, valid the cycle after its address
//     new_msg   in   1    first block of a message (chained build only)
//     w_read    out  1    registered read enable to the W generator
//     w_addr    out  6    registered W word index
//     hash_out  out  256  digest H0..H7, H0 in [255:224]
//     hash_rdy  out  1    one-cycle digest-valid pulse
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         w_rdy,
    input  logic [31:0]  w_data,
    input  logic         new_msg,
    output logic         w_read,
    output logic [5:0]   w_addr,
    output logic [255:0] hash_out,
    output logic         hash_rdy
);

    state_t      state;
    state_t      state_nxt;
    logic        w_rdy_q;
    logic        start;
    logic [5:0]  t;
    hash_t       h_state;
    hash_t       work;
    hash_t       work_nxt;
    hash_t       base;
    hash_t       h_sum;

    // w_rdy history is tracked in every state so a level that rose while
    // busy is not seen as a fresh edge once the block returns to IDLE.
    assign start = w_rdy & ~w_rdy_q;

`ifdef SHA256_CHAIN_EN
    assign base = new_msg ? IV : h_state;
`else
    logic unused_new_msg;
    assign unused_new_msg = new_msg;
    assign base = IV;
`endif

    sha256_round u_round (
        .state_in  (work),
        .k         (K[t]),
        .w         (w_data),
        .state_out (work_nxt)
    );

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            h_sum[i] = h_state[i] + work[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = ROUND;
            ROUND:   if (t == 6'd63) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_rdy_q  <= 1'b0;
            w_read   <= 1'b0;
            w_addr   <= '0;
            hash_out <= '0;
            hash_rdy <= 1'b0;
            t        <= '0;
            h_state  <= IV;
            work     <= '0;
        end else begin
            w_rdy_q  <= w_rdy;
            hash_rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        h_state <= base;
                        work    <= base;
                        w_read  <= 1'b1;
                        w_addr  <= 6'd0;
                    end
                end
                FETCH: begin
                    w_addr <= 6'd1;
                    t      <= '0;
                end
                ROUND: begin
                    work <= work_nxt;
                    t    <= t + 6'd1;
                    // Address runs two ahead of the round; stop after 63.
                    if (t <= 6'd61) begin
                        w_addr <= t + 6'd2;
                    end else begin
                        w_read <= 1'b0;
                    end
                end
                FINAL: begin
                    h_state  <= h_sum;
                    hash_out <= h_sum;
                    hash_rdy <= 1'b1;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
module tb_sha256_compress;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         w_rdy = 1'b0;
    logic [31:0]  w_data = '0;
    logic         new_msg = 1'b0;
    logic         w_read;
    logic [5:0]   w_addr;
    logic [255:0] hash_out;
    logic         hash_rdy;

    int unsigned vectors = 0;
    int unsigned fails = 0;
    logic [255:0] exp_q[$];
    logic [31:0]  wmem [64];

    localparam logic [255:0] IV_T = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_compress dut (
        .clock    (clock),
        .reset    (reset),
        .w_rdy    (w_rdy),
        .w_data   (w_data),
        .new_msg  (new_msg),
        .w_read   (w_read),
        .w_addr   (w_addr),
        .hash_out (hash_out),
        .hash_rdy (hash_rdy)
    );

    always #5 clock = ~clock;

    // Behavioural W generator read port: one-cycle read latency.
    always @(posedge clock) begin
        if (w_read) w_data <= wmem[w_addr];
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void expand(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        expand(blk, w);
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int n = 0; n < 64; n++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[n] + w[n];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Starts one block and watches it to completion. w_rdy is held high
    // until cycle 'hold'; 'retrig' places a one-cycle w_rdy pulse while busy.
    task automatic run_block(input string tag, input logic [511:0] blk, input logic nm,
                             input int hold, input int retrig, input logic chk_addr,
                             input logic [255:0] expected);
        logic [31:0] w [64];
        logic [255:0] e;
        int n_rdy;
        int last;
        expand(blk, w);
        wmem = w;
        exp_q.push_back(expected);
        n_rdy = 0;
        last = (hold > 67 ? hold : 67) + 10;
        @(negedge clock);
        new_msg = nm;
        w_rdy = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            if (k == hold) w_rdy = 1'b0;
            if (k == retrig) w_rdy = 1'b1;
            if (k == retrig + 1) w_rdy = 1'b0;
            if (chk_addr && k <= 64) check({tag, " rd_addr"}, 256'({w_read, w_addr}), 256'({1'b1, 6'(k - 1)}));
            if (chk_addr && k == 65) check({tag, " rd_end"}, 256'(w_read), 256'(0));
            if (hash_rdy) begin
                n_rdy++;
                if (n_rdy == 1) begin
                    check({tag, " latency"}, 256'(k), 256'(67));
                    if (exp_q.size() == 0) begin
                        check({tag, " queue"}, 256'(0), 256'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, " digest"}, hash_out, e);
                    end
                end
            end
        end
        check({tag, " rdy_count"}, 256'(n_rdy), 256'(1));
    endtask

    initial begin
        int cnt;
        logic [255:0] exp2;

        // Reset defaults.
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("in_reset", {hash_out, 1'b0}, 257'(0) | 257'({w_read, w_addr, hash_rdy}) ^ 257'({w_read, w_addr, hash_rdy}) ? 257'(0) : 257'(0));
        check("reset_outs", 256'({w_read, w_addr, hash_rdy}), 256'(0));
        reset = 1'b1;
        @(negedge clock);
        check("reset_hash", hash_out, 256'(0));
        check("reset_ctrl", 256'({w_read, w_addr, hash_rdy}), 256'(0));
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (w_read || hash_rdy) cnt++;
        end
        check("idle_no_read", 256'(cnt), 256'(0));

        run_block("abc", BLK_ABC, 1'b1, 1, 1000, 1'b1, DIG_ABC);
        run_block("empty_held", BLK_EMPTY, 1'b1, 200, 1000, 1'b0, DIG_EMPTY);
        run_block("busy_retrig", BLK_ABC, 1'b1, 1, 30, 1'b0, DIG_ABC);

        run_block("two_blk1", BLK_TWO1, 1'b1, 1, 1000, 1'b0, ref_compress(IV_T, BLK_TWO1));
`ifdef SHA256_CHAIN_EN
        exp2 = DIG_TWO;
`else
        exp2 = ref_compress(IV_T, BLK_TWO2);
        check("nochain_differs", 256'(exp2 != DIG_TWO), 256'(1));
`endif
        run_block("two_blk2", BLK_TWO2, 1'b0, 1, 1000, 1'b0, exp2);

        // Reset in the middle of a block.
        wmem = '{default: 32'h0};
        begin
            logic [31:0] w [64];
            expand(BLK_EMPTY, w);
            wmem = w;
        end
        @(negedge clock);
        new_msg = 1'b1;
        w_rdy = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) w_rdy = 1'b0;
        end
        check("mid_busy", 256'(w_read), 256'(1));
        reset = 1'b0;
        #1;
        check("mid_reset_hash", hash_out, 256'(0));
        check("mid_reset_ctrl", 256'({w_read, w_addr, hash_rdy}), 256'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (hash_rdy || w_read) cnt++;
        end
        check("mid_no_digest", 256'(cnt), 256'(0));

        run_block("abc_after_rst", BLK_ABC, 1'b1, 1, 1000, 1'b1, DIG_ABC);
        check("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Consumer of the W-schedule read port: once the message-schedule generator reports its 64 W words ready, this block fetches W[0..63] through the schedule's read/address interface, runs the 64 SHA-256 compression rounds (one per cycle), adds the working variables into the hash state, and presents the 256-bit digest with a ready pulse. It sits directly downstream of the W generator and is the final datapath stage of the accelerator.

## Interface
- No parameters; all widths are fixed by SHA-256.
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- w_rdy  in  1  schedule-ready level from the W generator
- w_data  in  32  W word; valid the cycle after the address is presented
- new_msg  in  1  sampled with the w_rdy rising edge: 1 = first block of a message (used only with `SHA256_CHAIN_EN`)
- w_read  out  1  read enable to the W generator (registered)
- w_addr  out  6  W word index (registered)
- hash_out  out  256  digest H0..H7, H0 in bits [255:224] (registered)
- hash_rdy  out  1  one-cycle digest-valid pulse (registered)

## Operation
- FSM states: IDLE, FETCH, ROUND, FINAL, DONE.
- IDLE: registers the previous w_rdy value. A 0→1 transition on w_rdy starts a block. A w_rdy held high does not retrigger.
- On start:
  - load working registers a..h from the hash state H;
  - assert w_read with w_addr=0;
  - go to FETCH.
- FETCH: issue w_addr=1 and go to ROUND with round counter t=0.
- ROUND, each cycle:
  - apply the round function with K[t] and w_data (which is W[t]);
  - issue w_addr=t+2 while t+2≤63. Deassert w_read after address 63 has been issued.
  - When t=63, go to FINAL.
- FINAL: H[i] ← H[i] + working[i], each word mod 2^32 (32-bit wrap, no carry out). hash_out ← new H. Go to DONE.
- DONE: hash_rdy=1 for one cycle, then return to IDLE. hash_out holds until the next FINAL.
- Arithmetic: all additions are 32-bit modular. Σ0, Σ1, Ch and Maj follow FIPS 180-4.
- w_rdy edges outside IDLE are ignored and not queued.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, H reloaded with IV. No partial digest is emitted.

## Timing
- Reset values: w_read=0, w_addr=0, hash_out=0, hash_rdy=0, H=IV, state=IDLE.
- Cycle numbering: the w_rdy rising edge is sampled at cycle 0.
  - Cycle 1: w_read=1, w_addr=0.
  - Cycle 2: w_addr=1; W[0] arrives.
  - Round t executes in cycle t+2 (rounds 0..63 in cycles 2..65).
  - w_read is high in cycles 1..64, with w_addr=k in cycle k+1.
- Cycle 66: FINAL; hash_out updates at the end of the cycle.
- Cycle 67: hash_rdy=1.
- Latency from sampled w_rdy edge to hash_rdy: 67 cycles. Minimum start-to-start spacing: 68 cycles.
- Read protocol: the W generator returns data exactly one cycle after a (w_read, w_addr) pair. This block never stalls.

## Configuration
- `SHA256_CHAIN_EN` defined:
  - H persists across blocks;
  - on a start with new_msg=1, H is reset to IV before loading a..h; with new_msg=0, the previous digest is chained.
  - Supports multi-block messages.
- Not defined:
  - every start reloads H from IV and new_msg is ignored;
  - single-block messages only.
  - Port list is identical in both builds.

## Structure
- Shared package sha256_pkg holds:
  - K[0..63] round constants;
  - IV H0..H7;
  - FSM state enum;
  - Σ0/Σ1/Ch/Maj functions.
  - The W generator reuses σ helpers from the same package.
- One sub-module, sha256_round: combinational single-round function taking {a..h}, K[t] and W[t] and returning the next {a..h}.
- Counter, FSM, hash-state adder and read sequencer live in the top module.

## Test plan
- Reset defaults: apply reset, hold for several cycles, release → all outputs 0 and state IDLE. w_rdy held low for 100 cycles → w_read never asserts.
- "abc" W schedule from a behavioural W model:
  - pulse w_rdy → hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
  - hash_rdy in cycle 67;
  - w_addr sequence 0..63 in cycles 1..64.
- Empty string: hold w_rdy high for 200 cycles → exactly one digest, e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- With `SHA256_CHAIN_EN`: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", new_msg=1 on the first block and 0 on the second → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Without the macro, the second block's digest differs (IV reloaded).
- Busy retrigger: a second w_rdy edge at cycle 30 is ignored; the digest is unchanged and hash_rdy still occurs at cycle 67.
- Reset mid-operation: assert reset at cycle 40 →
  - outputs 0 immediately;
  - no hash_rdy;
  - the next "abc" run still yields the correct digest.
